alu_or_arbiter: RTL and testbench
=================================

# alu_or_arbiter

Shares one segmented OR-reduce ALU (`alu_or_comb_dynamic`) between `NUM_REQ` requesters. Each requester has its own valid/ready request channel. Arbitration is round-robin. The ALU sits between two pipeline registers, and results leave on a single valid/ready response channel tagged with the requester index. The block sits between the issuing agents and the reduction datapath and is the only path by which agents reach it.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of the requester index; must equal clog2(`NUM_REQ`).

Ports:
- `clk`, input, 1: single clock; all state on the rising edge.
- `rst`, input, 1: reset. **Reset is synchronous and active-high.**
- `req_valid`, input, `NUM_REQ`: per-requester request valid.
- `req_ready`, output, `NUM_REQ`: per-requester grant/accept, one-hot or zero.
- `req_din`, input, `NUM_REQ`*32: operand of requester i in bits [i*32 +: 32].
- `req_funct`, input, `NUM_REQ`*3: segment select of requester i in bits [i*3 +: 3].
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_data`, output, 32: ALU result.
- `rsp_id`, output, `ID_W`: index of the requester that issued the response.
- `rsp_err`, output, 1: funct was 5..7; `rsp_data` is 32'hDEADBEEF.
- `done_cnt`, output, 16: count of completed response handshakes; wraps at 16'hFFFF to 0.

## Operation
Segmented OR-reduce semantics:
- funct 0: passthrough.
- funct 1, 2, 3, 4: OR-reduce each 2-, 4-, 8- or 16-bit segment into that segment's LSB; the other bits of the segment are 0.
- funct 5..7: 32'hDEADBEEF with `rsp_err`=1.

Pipeline:
- Stage S1 (operand register) holds `s1_valid`, `din`, `funct` and `id`.
- The ALU is combinational on S1.
- Stage S2 is the response register: `rsp_valid`, `rsp_data`, `rsp_err`, `rsp_id`.

Advance rules:
- `s2_load` = `s1_valid` & (!`rsp_valid` | `rsp_ready`).
- `s1_load` = any(`req_valid`) & (!`s1_valid` | `s2_load`).
- If `rsp_valid` & `rsp_ready` & !`s2_load`, `rsp_valid` clears.
- If `s1_valid` & `s2_load` & !`s1_load`, `s1_valid` clears.

Arbitration:
- Round-robin pointer `rr_ptr`; search order is `rr_ptr`, `rr_ptr`+1, … mod `NUM_REQ`.
- The first requester with `req_valid` set wins.
- `req_ready`[g] = `s1_load` for the winner g only; all other bits are 0.
- `req_ready` is combinational from `req_valid`, the pipeline state and `rsp_ready`.
- On grant, `rr_ptr` ← (g+1) mod `NUM_REQ`. With no grant, `rr_ptr` holds.
- A requester must hold `req_din`/`req_funct` stable while `req_valid`=1 and `req_ready`=0.

Counter:
- `done_cnt` increments on every cycle with `rsp_valid` & `rsp_ready`.

Reset (`rst`=1 at a rising edge), takes priority over everything:
- `s1_valid`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `rsp_id`=0, `rr_ptr`=0, `done_cnt`=0, hence `req_ready`=0.
- In-flight requests are dropped without response.

## Timing
- Latency: a request accepted at edge N (S1 loaded) gives `rsp_valid` after edge N+1, provided S2 is free or draining.
- Throughput: 1 request/cycle with `rsp_ready` held at 1.
- Maximum in flight: 2 (S1 + S2). With `rsp_ready`=0 and both stages full, all `req_ready` are 0.
- Simultaneous response drain and S1→S2 move in one cycle: allowed, with no bubble.
- `rsp_*` outputs stay stable while `rsp_valid`=1 and `rsp_ready`=0.

## Structure
- Shared package `alu_or_pkg`:
  - `FUNCT_*` constants 0..4.
  - `ALU_ERR_PATTERN` = 32'hDEADBEEF.
  - The funct-valid check function.
- Sub-module: one instance of `alu_or_comb_dynamic` driven from S1.
- Round-robin selection stays in-line; no further sub-modules.

## Test plan
- Requester 1 sends funct=2, din=32'h0000_F00F, `rsp_ready`=1 → one cycle after `req_ready`[1], `rsp_data`=32'h0000_1001, `rsp_id`=1, `rsp_err`=0, `done_cnt`=1.
- Requester 0 sends funct=3, din=32'h8000_0100 → `rsp_data`=32'h0100_0100. Then funct=4, din=32'h0001_0000 → `rsp_data`=32'h0001_0000.
- All 4 requesters hold valid, `rsp_ready`=1 → `req_ready` grants 0,1,2,3,0,1 on consecutive cycles; responses carry the same `rsp_id` sequence with no bubbles.
- `rsp_ready`=0 for 6 cycles with all requesters valid → exactly 2 grants, then `req_ready`=0. `rsp_*` is stable. On release, responses drain in grant order, one per cycle.
- funct=7, din=32'h1234_5678 → `rsp_data`=32'hDEADBEEF, `rsp_err`=1. A following funct=0 request → `rsp_err`=0 and the data passes through.
- `rst` asserted with S1 and S2 full → next cycle `rsp_valid`=0, `done_cnt`=0, `rr_ptr`=0. The first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/alu_or_pkg.sv
// alu_or_pkg
// Shared definitions for the segmented OR-reduce ALU and its arbiter front end.
//   FUNCT_*          : segment-select encodings 0..4 (pass, OR over 2/4/8/16 bits)
//   ALU_ERR_PATTERN  : result word returned for unsupported funct codes
//   funct_valid()    : true for funct codes the ALU implements
package alu_or_pkg;

  localparam logic [2:0] FUNCT_PASS = 3'd0;
  localparam logic [2:0] FUNCT_OR2  = 3'd1;
  localparam logic [2:0] FUNCT_OR4  = 3'd2;
  localparam logic [2:0] FUNCT_OR8  = 3'd3;
  localparam logic [2:0] FUNCT_OR16 = 3'd4;

  localparam logic [31:0] ALU_ERR_PATTERN = 32'hDEADBEEF;

  function automatic logic funct_valid(input logic [2:0] funct);
    return (funct <= FUNCT_OR16);
  endfunction

endpackage

// File: rtl/alu_or_comb_dynamic.sv
// alu_or_comb_dynamic
// Purely combinational segmented OR-reduce.
//   din_i   [31:0] : operand
//   funct_i [2:0]  : 0 pass, 1..4 OR-reduce segments of 2/4/8/16 bits into the
//                    segment LSB (other segment bits 0), 5..7 error
//   dout_o  [31:0] : result (ALU_ERR_PATTERN on error)
//   err_o          : funct_i was not a supported code
module alu_or_comb_dynamic
  import alu_or_pkg::*;
(
  input  logic [31:0] din_i,
  input  logic [2:0]  funct_i,
  output logic [31:0] dout_o,
  output logic        err_o
);

  // One precomputed result per segment width; funct_i only picks among them.
  logic [31:0] seg_or [1:4];

  genvar gi, gj;
  generate
    for (gi = 1; gi <= 4; gi++) begin : g_width
      localparam int SEG = 1 << gi;
      for (gj = 0; gj < 32 / SEG; gj++) begin : g_seg
        assign seg_or[gi][gj*SEG +: SEG] = {{(SEG-1){1'b0}}, |din_i[gj*SEG +: SEG]};
      end
    end
  endgenerate

  always_comb begin
    dout_o = din_i;
    err_o  = 1'b0;
    if (!funct_valid(funct_i)) begin
      dout_o = ALU_ERR_PATTERN;
      err_o  = 1'b1;
    end else begin
      case (funct_i)
        FUNCT_OR2:  dout_o = seg_or[1];
        FUNCT_OR4:  dout_o = seg_or[2];
        FUNCT_OR8:  dout_o = seg_or[3];
        FUNCT_OR16: dout_o = seg_or[4];
        default:    dout_o = din_i;
      endcase
    end
  end

endmodule

// File: rtl/alu_or_arbiter.sv
// alu_or_arbiter
// Round-robin front end sharing one segmented OR-reduce ALU between NUM_REQ
// requesters. Two register stages: S1 holds the granted operand, the ALU works
// combinationally on S1, S2 is the response register.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready [N]  : per-requester handshake (ready one-hot or zero)
//   req_din   [N*32]         : operand of requester i at [i*32 +: 32]
//   req_funct [N*3]          : segment select of requester i at [i*3 +: 3]
//   rsp_valid/rsp_ready      : response handshake
//   rsp_data, rsp_id, rsp_err: result, issuing requester, unsupported-funct flag
//   done_cnt [16]            : completed response handshakes (wrapping)
module alu_or_arbiter
  import alu_or_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_din,
  input  logic [NUM_REQ*3-1:0] req_funct,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_err,
  output logic [15:0]          done_cnt
);

  // Pipeline state
  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_din_q,   s1_din_d;
  logic [2:0]      s1_funct_q, s1_funct_d;
  logic [ID_W-1:0] s1_id_q,    s1_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q,  rsp_data_d;
  logic            rsp_err_q,   rsp_err_d;
  logic [ID_W-1:0] rsp_id_q,    rsp_id_d;
  logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic [15:0]     done_cnt_q,  done_cnt_d;

  // Per-requester operand views
  logic [31:0] din_arr   [NUM_REQ];
  logic [2:0]  funct_arr [NUM_REQ];

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand_id;
  logic [ID_W:0]   cand_sum;
  logic            s1_load;
  logic            s2_load;
  logic            rsp_fire;
  logic [31:0]     alu_dout;
  logic            alu_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign din_arr[gi]   = req_din[gi*32 +: 32];
      assign funct_arr[gi] = req_funct[gi*3 +: 3];
      assign req_ready[gi] = s1_load && (win_id == ID_W'(gi));
    end
  endgenerate

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_id   = '0;
    cand_sum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      end
      cand_id = cand_sum[ID_W-1:0];
      if (!win_found && req_valid[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  assign rsp_fire = rsp_valid_q && rsp_ready;
  assign s2_load  = s1_valid_q && (!rsp_valid_q || rsp_ready);
  // Grants are suppressed while reset is asserted: an accept in that cycle
  // would be discarded by the reset anyway.
  assign s1_load  = !rst && win_found && (!s1_valid_q || s2_load);

  alu_or_comb_dynamic u_alu (
    .din_i   (s1_din_q),
    .funct_i (s1_funct_q),
    .dout_o  (alu_dout),
    .err_o   (alu_err)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_din_d    = s1_din_q;
    s1_funct_d  = s1_funct_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    done_cnt_d  = done_cnt_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_din_d   = din_arr[win_id];
      s1_funct_d = funct_arr[win_id];
      s1_id_d    = win_id;
      rr_ptr_d   = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Loading S2 while the old response drains keeps throughput at one per cycle.
    if (s2_load) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = alu_dout;
      rsp_err_d   = alu_err;
      rsp_id_d    = s1_id_q;
    end else if (rsp_fire) begin
      rsp_valid_d = 1'b0;
    end

    if (rsp_fire) begin
      done_cnt_d = done_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_din_q    <= '0;
      s1_funct_q  <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
      done_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_din_q    <= s1_din_d;
      s1_funct_q  <= s1_funct_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = rsp_id_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_or_arbiter.sv
// tb_alu_or_arbiter
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model: a queue of accepted requests (capacity two) whose
// head becomes visible one cycle after acceptance.
module tb_alu_or_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_din;
  logic [NUM_REQ*3-1:0]  req_funct;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_err;
  logic [15:0]           done_cnt;

  alu_or_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din   (req_din),
    .req_funct (req_funct),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU: {err, data}
  function automatic logic [32:0] model_alu(input logic [2:0] f, input logic [31:0] d);
    logic [31:0] r;
    int          seg;
    logic [63:0] mask;
    r = '0;
    if (f == 3'd0) return {1'b0, d};
    if (f > 3'd4)  return {1'b1, 32'hDEADBEEF};
    seg  = 1 << f;
    mask = (64'd1 << seg) - 64'd1;
    for (int s = 0; s < 32; s += seg) begin
      r[s] = ((64'(d) >> s) & mask) != 64'd0;
    end
    return {1'b0, r};
  endfunction

  // Transaction-level model state
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          id;
    int          acc;
  } rsp_t;

  rsp_t               pend[$];
  int                 rr_m     = 0;
  logic [15:0]        done_m   = '0;
  int                 cyc      = 0;
  logic [NUM_REQ-1:0] last_ready = '0;

  // Compare process: inputs are stable at the falling edge.
  always @(negedge clk) begin
    logic               exp_rv;
    logic               can;
    int                 g;
    int                 c;
    logic [NUM_REQ-1:0] exp_ready;
    logic [32:0]        r;
    rsp_t               e;

    exp_rv = (pend.size() > 0) && (pend[0].acc < cyc);
    // Two in flight at most; a slot frees this cycle if the head is consumed.
    can = !rst && ((pend.size() < 2) || (exp_rv && rsp_ready));
    g = -1;
    if (can) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (rr_m + k) % NUM_REQ;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;

    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("done_cnt",  32'(done_cnt),  32'(done_m));
    if (exp_rv) begin
      check("rsp_data", rsp_data,       pend[0].data);
      check("rsp_id",   32'(rsp_id),    32'(pend[0].id));
      check("rsp_err",  32'(rsp_err),   32'(pend[0].err));
    end
    last_ready = req_ready;

    if (rst) begin
      pend.delete();
      rr_m   = 0;
      done_m = '0;
    end else begin
      if (exp_rv && rsp_ready) begin
        void'(pend.pop_front());
        done_m = done_m + 16'd1;
      end
      if (g >= 0) begin
        r      = model_alu(req_funct[g*3 +: 3], req_din[g*32 +: 32]);
        e.data = r[31:0];
        e.err  = r[32];
        e.id   = g;
        e.acc  = cyc + 1;
        pend.push_back(e);
        rr_m = (g + 1) % NUM_REQ;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] f, input logic [31:0] d);
    req_valid[i]        = v;
    req_funct[i*3 +: 3]  = f;
    req_din[i*32 +: 32]  = d;
  endtask

  initial begin
    logic [32:0]        mr;
    logic [NUM_REQ-1:0] glog [8];
    logic               vlog [8];
    int                 idlog [8];
    int                 gids[$];
    int                 cnt;
    int                 exp_g [6];
    logic [NUM_REQ-1:0] exp_oh [6];

    rst       = 1'b1;
    req_valid = '0;
    req_din   = '0;
    req_funct = '0;
    rsp_ready = 1'b0;

    // Pin the reference ALU with hand-computed values
    mr = model_alu(3'd2, 32'h0000_F00F); check("model_or4",  mr[31:0], 32'h0000_1001);
    mr = model_alu(3'd3, 32'h8000_0100); check("model_or8",  mr[31:0], 32'h0100_0100);
    mr = model_alu(3'd4, 32'h0001_0000); check("model_or16", mr[31:0], 32'h0001_0000);
    mr = model_alu(3'd1, 32'h0000_0006); check("model_or2",  mr[31:0], 32'h0000_0005);
    mr = model_alu(3'd7, 32'h1234_5678); check("model_err",  32'(mr[32]), 32'd1);
    mr = model_alu(3'd0, 32'hCAFE_F00D); check("model_pass", mr[31:0], 32'hCAFE_F00D);

    repeat (3) step();
    rst       = 1'b0;
    rsp_ready = 1'b1;

    // Requester 1, funct 2
    set_req(1, 1'b1, 3'd2, 32'h0000_F00F);
    @(negedge clk); check("t1_grant", 32'(req_ready), 32'h2);
    step(); set_req(1, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    step();
    @(negedge clk);
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_data",  rsp_data, 32'h0000_1001);
    check("t1_id",    32'(rsp_id), 32'd1);
    check("t1_err",   32'(rsp_err), 32'd0);
    step();
    @(negedge clk); check("t1_done", 32'(done_cnt), 32'd1);

    // Requester 0, funct 3 then funct 4 back to back
    set_req(0, 1'b1, 3'd3, 32'h8000_0100);
    @(negedge clk); check("t2_grant_a", 32'(req_ready), 32'h1);
    step(); set_req(0, 1'b1, 3'd4, 32'h0001_0000);
    @(negedge clk); check("t2_grant_b", 32'(req_ready), 32'h1);
    step(); set_req(0, 1'b0, 3'd0, 32'h0);
    @(negedge clk); check("t2_data_a", rsp_data, 32'h0100_0100);
    step();
    @(negedge clk); check("t2_data_b", rsp_data, 32'h0001_0000);
    step();

    // All four valid, rsp_ready=1: grants rotate with no bubbles
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 3'($urandom_range(0, 4)), $urandom);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      glog[k]  = req_ready;
      vlog[k]  = rsp_valid;
      idlog[k] = rsp_id;
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (k >= 5) set_req(i, 1'b0, 3'd0, 32'h0);
        else if (glog[k][i]) set_req(i, 1'b1, 3'($urandom_range(0, 4)), $urandom);
      end
    end
    exp_g  = '{0, 1, 2, 3, 0, 1};
    exp_oh = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_grant%0d", k), 32'(glog[k]), 32'(exp_oh[k]));
      check($sformatf("rr_rspv%0d", k), 32'(vlog[k+2]), 32'd1);
      check($sformatf("rr_rspid%0d", k), 32'(idlog[k+2]), 32'(exp_g[k]));
    end

    // Back-pressure: only two accepted, then drained in grant order
    repeat (3) step();
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 3'($urandom_range(0, 4)), $urandom);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) begin
          cnt++;
          gids.push_back(i);
        end
      end
      step();
    end
    check("stall_grants", 32'(cnt), 32'd2);
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("drain0_valid", 32'(rsp_valid), 32'd1);
    if (gids.size() > 0) check("drain0_id", 32'(rsp_id), 32'(gids[0]));
    step();
    @(negedge clk);
    check("drain1_valid", 32'(rsp_valid), 32'd1);
    if (gids.size() > 1) check("drain1_id", 32'(rsp_id), 32'(gids[1]));
    step();
    repeat (2) step();

    // Error funct, then passthrough
    set_req(2, 1'b1, 3'd7, 32'h1234_5678);
    @(negedge clk); check("err_grant", 32'(req_ready), 32'h4);
    step(); set_req(2, 1'b1, 3'd0, 32'hCAFE_F00D);
    @(negedge clk);
    step(); set_req(2, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    check("err_data", rsp_data, 32'hDEADBEEF);
    check("err_flag", 32'(rsp_err), 32'd1);
    step();
    @(negedge clk);
    check("pass_data", rsp_data, 32'hCAFE_F00D);
    check("pass_err",  32'(rsp_err), 32'd0);
    step();

    // Reset with both stages full
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 3'($urandom_range(0, 4)), $urandom);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1001;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_done_cnt",  32'(done_cnt), 32'd0);
    check("rst_first_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (3) step();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 599) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!(req_valid[i] && !last_ready[i])) begin
          set_req(i, 1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) != 0) ? ($urandom & $urandom & $urandom) : $urandom);
        end
      end
      step();
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
